bram_dram_responder: RTL and testbench



---
 rtl/d16_mem_pkg.sv | 19 +
 rtl/bram_sp.sv | 30 +++
 rtl/bram_dram_responder.sv | 162 ++++++++++++++++
 tb/tb_bram_dram_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/d16_mem_pkg.sv
// Shared types and constants for the BRAM-backed DRAM responder.
package d16_mem_pkg;

    localparam int unsigned D16_ADDR_W = 24;
    localparam int unsigned D16_DATA_W = 32;

    // Read data returned for addresses outside the implemented RAM.
    localparam logic [31:0] D16_OOR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        RESP,
        GAP,
        REFRESH
    } resp_state_t;

endpackage

// File: rtl/bram_sp.sv
// Single-port synchronous RAM, registered read, write-first; shaped for block RAM inference.
module bram_sp
    import d16_mem_pkg::*;
#(
    parameter int unsigned DATA_W = D16_DATA_W,
    parameter int unsigned AW     = 12
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1 << AW) - 1];

    // Storage and output register; rdata only changes on an enabled access.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/bram_dram_responder.sv
// DRAM request-protocol responder backed by on-chip RAM with programmable latency.
// Optional emulated refresh stalls: define BRAM_RESP_REFRESH_EN.
module bram_dram_responder
    import d16_mem_pkg::*;
#(
    parameter int unsigned       ADDR_W         = D16_ADDR_W,
    parameter int unsigned       DATA_W         = D16_DATA_W,
    parameter int unsigned       MEM_AW         = 12,
    parameter int unsigned       READ_LAT       = 4,
    parameter int unsigned       WRITE_LAT      = 2,
    parameter logic [DATA_W-1:0] OOR_DATA       = D16_OOR_DATA,
    parameter int unsigned       REFRESH_PERIOD = 780,
    parameter int unsigned       REFRESH_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              write_complete,
    output logic              busy
);

    localparam int unsigned CNT_W = 8;

    resp_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic              oor;
    logic              in_range;
    logic              hold_off;
    logic              accept_wr;
    logic              accept_rd;
    logic [DATA_W-1:0] ram_rdata;

    assign in_range = (address[ADDR_W-1:MEM_AW] == '0);

`ifdef BRAM_RESP_REFRESH_EN
    localparam int unsigned REF_W = 16;

    logic [REF_W-1:0] ref_cnt;
    logic             ref_wrap;
    logic             ref_pend;

    assign ref_wrap = (ref_cnt == REF_W'(REFRESH_PERIOD - 1));
    // A wrap landing in an IDLE cycle wins over a request in that same cycle.
    assign hold_off = ref_pend | ref_wrap;

    // Free-running refresh timer and pending flag, cleared when REFRESH is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt  <= '0;
            ref_pend <= 1'b0;
        end else begin
            ref_cnt  <= ref_wrap ? '0 : ref_cnt + REF_W'(1);
            ref_pend <= (ref_pend | ref_wrap) & (state != IDLE);
        end
    end
`else
    logic unused_refresh_cfg;
    assign unused_refresh_cfg = ^{REFRESH_PERIOD, REFRESH_CYCLES};
    assign hold_off = 1'b0;
`endif

    // The RAM is accessed on the acceptance edge with the live address, so read data is
    // already registered by the first wait cycle even at the minimum read latency.
    assign accept_wr = (state == IDLE) && !hold_off && req_write;
    assign accept_rd = (state == IDLE) && !hold_off && req_read && !req_write;

    bram_sp #(
        .DATA_W (DATA_W),
        .AW     (MEM_AW)
    ) u_ram (
        .clk   (clk),
        .en    ((accept_wr && in_range) || accept_rd),
        .we    (accept_wr && in_range),
        .addr  (address[MEM_AW-1:0]),
        .wdata (data_in),
        .rdata (ram_rdata)
    );

    // Transaction FSM with latency counter and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            oor            <= 1'b0;
            data_out       <= '0;
            data_valid     <= 1'b0;
            write_complete <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_valid     <= 1'b0;
            write_complete <= 1'b0;
            unique case (state)
                IDLE: begin
`ifdef BRAM_RESP_REFRESH_EN
                    if (hold_off) begin
                        state <= REFRESH;
                        cnt   <= CNT_W'(REFRESH_CYCLES - 1);
                        busy  <= 1'b1;
                    end else
`endif
                    if (req_write) begin
                        oor  <= !in_range;
                        busy <= 1'b1;
                        if (WRITE_LAT == 1) begin
                            state          <= RESP;
                            write_complete <= 1'b1;
                        end else begin
                            state <= WR_WAIT;
                            cnt   <= CNT_W'(WRITE_LAT - 1);
                        end
                    end else if (req_read) begin
                        oor   <= !in_range;
                        busy  <= 1'b1;
                        state <= RD_WAIT;
                        cnt   <= CNT_W'(READ_LAT - 1);
                    end
                end
                RD_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state      <= RESP;
                        data_valid <= 1'b1;
                        data_out   <= oor ? OOR_DATA : ram_rdata;
                    end
                end
                WR_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state          <= RESP;
                        write_complete <= 1'b1;
                    end
                end
                RESP: begin
                    state <= GAP;
                end
                GAP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
`ifdef BRAM_RESP_REFRESH_EN
                REFRESH: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_dram_responder.sv
// Self-checking bench for bram_dram_responder against a word-addressed memory model.
module tb_bram_dram_responder;

    localparam int unsigned READ_LAT  = 4;
    localparam int unsigned WRITE_LAT = 2;
    localparam logic [31:0] OOR       = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] address;
    logic        req_read;
    logic        req_write;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        data_valid;
    logic        write_complete;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [int];
    logic [31:0] last_read_data;
    logic [23:0] pool [6];

    always #5 clk = ~clk;

    bram_dram_responder #(
        .ADDR_W         (24),
        .DATA_W         (32),
        .MEM_AW         (12),
        .READ_LAT       (READ_LAT),
        .WRITE_LAT      (WRITE_LAT),
        .OOR_DATA       (OOR),
        .REFRESH_PERIOD (20),
        .REFRESH_CYCLES (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .address        (address),
        .req_read       (req_read),
        .req_write      (req_write),
        .data_in        (data_in),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .write_complete (write_complete),
        .busy           (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [23:0] a);
        if (a[23:12] != 12'h0) return OOR;
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return 32'h0;
    endfunction

    // Counts negedges from the current one until a response pulse; lat=-1 on timeout.
    task automatic await_pulse(output int lat, output bit is_rd, output logic [31:0] dout);
        lat   = -1;
        is_rd = 1'b0;
        dout  = '0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (data_valid || write_complete) begin
                lat   = n;
                is_rd = data_valid;
                dout  = data_out;
                break;
            end
        end
    endtask

    // Issues one request (write, read, or both) from an IDLE negedge and checks responses.
    task automatic txn(input string tag, input bit wr, input bit rd,
                       input logic [23:0] a, input logic [31:0] d);
        int          lat;
        bit          is_rd;
        logic [31:0] dout;
        address   = a;
        data_in   = d;
        req_write = wr;
        req_read  = rd;
        if (wr) begin
            await_pulse(lat, is_rd, dout);
            check_val({tag, "_wlat"}, 32'(lat), 32'(WRITE_LAT));
            check_val({tag, "_wkind"}, {31'b0, is_rd}, 32'd0);
            if (a[23:12] == 12'h0) ref_mem[int'(a)] = d;
            req_write = 1'b0;
            if (rd) begin
                // Pending read is accepted after GAP and one IDLE cycle.
                await_pulse(lat, is_rd, dout);
                check_val({tag, "_rlat_after_w"}, 32'(lat), 32'(2 + READ_LAT));
                check_val({tag, "_rkind"}, {31'b0, is_rd}, 32'd1);
                check_val({tag, "_rdata"}, dout, model_read(a));
                last_read_data = model_read(a);
            end
        end else if (rd) begin
            await_pulse(lat, is_rd, dout);
            check_val({tag, "_rlat"}, 32'(lat), 32'(READ_LAT));
            check_val({tag, "_rkind"}, {31'b0, is_rd}, 32'd1);
            check_val({tag, "_rdata"}, dout, model_read(a));
            last_read_data = model_read(a);
        end
        req_read  = 1'b0;
        req_write = 1'b0;
        @(negedge clk);
        check_val({tag, "_gap_busy"}, {31'b0, busy}, 32'd1);
        check_val({tag, "_hold"}, data_out, last_read_data);
        @(negedge clk);
        check_val({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic held_read_test();
        int          lat;
        bit          is_rd;
        logic [31:0] dout;
        int          extra;
        address  = 24'h000010;
        req_read = 1'b1;
        await_pulse(lat, is_rd, dout);
        check_val("held_first_lat", 32'(lat), 32'(READ_LAT));
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 3) req_read = 1'b0;
            if (data_valid) begin
                lat  = n;
                dout = data_out;
                break;
            end
        end
        check_val("held_spacing", 32'(lat), 32'(READ_LAT + 2));
        check_val("held_data", dout, model_read(24'h000010));
        last_read_data = dout;
        extra = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (data_valid || write_complete) extra++;
        end
        check_val("held_no_third", 32'(extra), 32'd0);
    endtask

    task automatic reset_mid_read_test();
        int pulses;
        pulses   = 0;
        address  = 24'h000010;
        req_read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("rst_busy", {31'b0, busy}, 32'd0);
        check_val("rst_dout", data_out, 32'd0);
        req_read = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (data_valid) pulses++;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (data_valid) pulses++;
        end
        check_val("rst_no_pulse", 32'(pulses), 32'd0);
        last_read_data = 32'h0;
        txn("rst_after", 1'b0, 1'b1, 24'h000010, 32'h0);
    endtask

    task automatic random_test();
        logic [23:0] a;
        int          k;
        for (int i = 0; i < 6; i++) begin
            pool[i] = {12'h0, 12'($urandom)};
            txn("rnd_init", 1'b1, 1'b0, pool[i], $urandom);
        end
        for (int i = 0; i < 40; i++) begin
            k = int'($urandom_range(0, 5));
            a = pool[k];
            // Out-of-range addresses alias a pool entry's low bits to catch bad decoding.
            if ($urandom_range(0, 4) == 0) a = {12'($urandom_range(1, 4095)), pool[k][11:0]};
            case ($urandom_range(0, 2))
                0:       txn("rnd_rd", 1'b0, 1'b1, a, $urandom);
                1:       txn("rnd_wr", 1'b1, 1'b0, a, $urandom);
                default: txn("rnd_both", 1'b1, 1'b1, a, $urandom);
            endcase
        end
    endtask

`ifdef BRAM_RESP_REFRESH_EN
    task automatic refresh_test();
        int last;
        int gap;
        int long_gaps;
        int bad_gaps;
        int bad_data;
        last      = -1;
        long_gaps = 0;
        bad_gaps  = 0;
        bad_data  = 0;
        address   = 24'h001000;
        req_read  = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (data_valid) begin
                if (data_out !== OOR) bad_data++;
                if (last >= 0) begin
                    gap = c - last;
                    if (gap == READ_LAT + 2 + 8) long_gaps++;
                    else if (gap != READ_LAT + 2) bad_gaps++;
                end
                last = c;
            end
        end
        req_read = 1'b0;
        check_val("rf_bad_data", 32'(bad_data), 32'd0);
        check_val("rf_bad_gaps", 32'(bad_gaps), 32'd0);
        check_val("rf_enough_refresh", {31'b0, long_gaps >= 18}, 32'd1);
    endtask
`endif

    initial begin
        rst_n          = 1'b0;
        address        = '0;
        req_read       = 1'b0;
        req_write      = 1'b0;
        data_in        = '0;
        last_read_data = '0;
        repeat (3) @(negedge clk);
        check_val("reset_dout", data_out, 32'd0);
        check_val("reset_dv", {31'b0, data_valid}, 32'd0);
        check_val("reset_wc", {31'b0, write_complete}, 32'd0);
        check_val("reset_busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
`ifdef BRAM_RESP_REFRESH_EN
        refresh_test();
`else
        txn("wr10", 1'b1, 1'b0, 24'h000010, 32'h1234_5678);
        txn("rd10", 1'b0, 1'b1, 24'h000010, 32'h0);
        txn("oor_wr", 1'b1, 1'b0, 24'h001010, 32'hAAAA_5555);
        txn("oor_rd", 1'b0, 1'b1, 24'h001010, 32'h0);
        txn("rd10_again", 1'b0, 1'b1, 24'h000010, 32'h0);
        txn("both20", 1'b1, 1'b1, 24'h000020, 32'hCAFE_F00D);
        held_read_test();
        reset_mid_read_test();
        random_test();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
